dispatcher: RTL and testbench

Decode-and-issue stage directly upstream of the reservation station and load/store buffer. Accepts one fetched instruction per cycle, decodes it, resolves source operands from the register file, the ROB and live result broadcasts, and holds it in a one-entry stage register. It issues on a shared bus to the ROB plus either the RS (ALU/branch/jump class) or the LSB (load/store class) once all targets have room, and renames `rd` in the register file.

---
 rtl/dispatcher_if.sv | 46 ++++
 rtl/dispatcher.sv | 95 +++++++++
 tb/tb_dispatcher.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispatcher_if.sv
// dispatcher_if: fetch, register-file, ROB, target and issue-bus signals of the dispatcher
interface dispatcher_if;
  logic rdy, rollback;
  logic if_valid, if_pred_jump, if_ready;
  logic [31:0] if_inst, if_pc;
  logic [4:0] rf_rs1_pos, rf_rs2_pos, rf_rs1_rob_id, rf_rs2_rob_id;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic [3:0] rob_rs1_pos, rob_rs2_pos, rob_nxt_pos;
  logic rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_val, rob_rs2_val;
  logic rob_nxt_full, rs_nxt_full, lsb_nxt_full;
  logic alu_result, lsb_result;
  logic [3:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic rob_issue, rs_issue, lsb_issue, rf_rename;
  logic [3:0] issue_rob_pos;
  logic [6:0] issue_opcode;
  logic [2:0] issue_funct3;
  logic issue_funct7, issue_pred_jump;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [4:0] issue_rs1_rob_id, issue_rs2_rob_id, issue_rd;
  modport master (
    input rdy, rollback, if_valid, if_inst, if_pc, if_pred_jump,
    input rf_rs1_val, rf_rs2_val, rf_rs1_rob_id, rf_rs2_rob_id,
    input rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    input rob_nxt_full, rs_nxt_full, lsb_nxt_full, rob_nxt_pos,
    input alu_result, alu_result_rob_pos, alu_result_val,
    input lsb_result, lsb_result_rob_pos, lsb_result_val,
    output if_ready, rf_rs1_pos, rf_rs2_pos, rob_rs1_pos, rob_rs2_pos,
    output rob_issue, rs_issue, lsb_issue, rf_rename, issue_rob_pos,
    output issue_opcode, issue_funct3, issue_funct7, issue_rs1_val, issue_rs2_val,
    output issue_rs1_rob_id, issue_rs2_rob_id, issue_imm, issue_rd, issue_pc, issue_pred_jump
  );
  modport slave (
    output rdy, rollback, if_valid, if_inst, if_pc, if_pred_jump,
    output rf_rs1_val, rf_rs2_val, rf_rs1_rob_id, rf_rs2_rob_id,
    output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    output rob_nxt_full, rs_nxt_full, lsb_nxt_full, rob_nxt_pos,
    output alu_result, alu_result_rob_pos, alu_result_val,
    output lsb_result, lsb_result_rob_pos, lsb_result_val,
    input if_ready, rf_rs1_pos, rf_rs2_pos, rob_rs1_pos, rob_rs2_pos,
    input rob_issue, rs_issue, lsb_issue, rf_rename, issue_rob_pos,
    input issue_opcode, issue_funct3, issue_funct7, issue_rs1_val, issue_rs2_val,
    input issue_rs1_rob_id, issue_rs2_rob_id, issue_imm, issue_rd, issue_pc, issue_pred_jump
  );
endinterface

// File: rtl/dispatcher.sv
// dispatcher: decode, operand resolve and one-entry issue stage feeding ROB plus RS or LSB
module dispatcher (
  input logic clk,
  input logic rst,
  dispatcher_if.master d
);
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP = 7'b0110011;
  typedef struct packed {
    logic [31:0] val;
    logic [4:0] id;
  } opnd_t;
  logic s_valid, s_f7, s_pj, f7, use1, use2, s_lsb, go, acc;
  logic [6:0] s_opc, opc;
  logic [2:0] s_f3;
  logic [4:0] s_rd;
  logic [31:0] s_imm, s_pc, imm, i;
  opnd_t s_a, s_b, a_dec, b_dec, a_cap, b_cap;
  function automatic opnd_t capture(opnd_t o);
    return (o.id[4] && d.alu_result && d.alu_result_rob_pos == o.id[3:0]) ? opnd_t'{d.alu_result_val, 5'd0} :
      (o.id[4] && d.lsb_result && d.lsb_result_rob_pos == o.id[3:0]) ? opnd_t'{d.lsb_result_val, 5'd0} : o;
  endfunction
  function automatic opnd_t resolve(logic [4:0] rs, logic used, logic [31:0] rfv, logic [4:0] rfid,
                                    logic robr, logic [31:0] robv);
    opnd_t c;
    c = capture(opnd_t'{32'd0, rfid});
    return (!used || rs == 5'd0) ? opnd_t'(0) :
      (d.rf_rename && d.issue_rd == rs) ? opnd_t'{32'd0, {1'b1, d.issue_rob_pos}} :
      !rfid[4] ? opnd_t'{rfv, 5'd0} :
      !c.id[4] ? c :
      robr ? opnd_t'{robv, 5'd0} : c;
  endfunction
  always_comb begin
    i = d.if_inst;
    opc = i[6:0];
    imm = (opc == OP_IMM || opc == LOAD || opc == JALR) ? {{20{i[31]}}, i[31:20]} :
      opc == STORE ? {{20{i[31]}}, i[31:25], i[11:7]} :
      opc == BRANCH ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
      (opc == LUI || opc == AUIPC) ? {i[31:12], 12'd0} :
      opc == JAL ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'd0;
    f7 = (opc == OP || (opc == OP_IMM && i[14:12] == 3'b101)) && i[30];
    use1 = !(opc == LUI || opc == AUIPC || opc == JAL);
    use2 = opc == OP || opc == STORE || opc == BRANCH;
    d.rf_rs1_pos = i[19:15];
    d.rf_rs2_pos = i[24:20];
    d.rob_rs1_pos = d.rf_rs1_rob_id[3:0];
    d.rob_rs2_pos = d.rf_rs2_rob_id[3:0];
    a_dec = resolve(i[19:15], use1, d.rf_rs1_val, d.rf_rs1_rob_id, d.rob_rs1_ready, d.rob_rs1_val);
    b_dec = resolve(i[24:20], use2, d.rf_rs2_val, d.rf_rs2_rob_id, d.rob_rs2_ready, d.rob_rs2_val);
  end
  always_comb begin
    s_lsb = s_opc == LOAD || s_opc == STORE;
    go = s_valid && !d.rollback && !d.rob_nxt_full && !(s_lsb ? d.lsb_nxt_full : d.rs_nxt_full);
    a_cap = capture(s_a);
    b_cap = capture(s_b);
    d.rob_issue = go;
    d.rs_issue = go && !s_lsb;
    d.lsb_issue = go && s_lsb;
    d.rf_rename = go && s_rd != 5'd0 && s_opc != STORE && s_opc != BRANCH;
    d.if_ready = !d.rollback && (!s_valid || go);
    acc = d.if_valid && d.if_ready;
    d.issue_rob_pos = d.rob_nxt_pos;
    d.issue_opcode = s_opc;
    d.issue_funct3 = s_f3;
    d.issue_funct7 = s_f7;
    d.issue_imm = s_imm;
    d.issue_rd = s_rd;
    d.issue_pc = s_pc;
    d.issue_pred_jump = s_pj;
    d.issue_rs1_val = a_cap.val;
    d.issue_rs1_rob_id = a_cap.id;
    d.issue_rs2_val = b_cap.val;
    d.issue_rs2_rob_id = b_cap.id;
  end
  always_ff @(posedge clk)
    if (rst) s_valid <= 1'b0;
    else if (d.rdy) begin
      s_valid <= acc || (s_valid && !go && !d.rollback);
      if (acc) begin
        s_opc <= opc;
        s_f3 <= i[14:12];
        s_f7 <= f7;
        s_rd <= i[11:7];
        s_imm <= imm;
        s_pc <= d.if_pc;
        s_pj <= d.if_pred_jump;
        s_a <= a_dec;
        s_b <= b_dec;
      end else begin
        s_a <= a_cap;
        s_b <= b_cap;
      end
    end
endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: directed scenarios and randomized decode/issue checks against a reference model
module tb_dispatcher;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_bad = 0;
  dispatcher_if bus ();
  dispatcher dut (.clk(clk), .rst(rst), .d(bus));
  always #5 clk = ~clk;
  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [31:0] t_inst [5] = '{32'hfe208ee3, 32'hffdff0ef, 32'habcde2b7, 32'h80000317, 32'h40315093};
  logic [31:0] t_imm [5] = '{32'hfffffffc, 32'hfffffffc, 32'habcde000, 32'h80000000, 32'h00000403};
  logic t_ren [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic t_f7 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] inst, pc;
  logic [36:0] ea, eb, ba, bb;
  logic pj, go, lsb, pend, rdy_now;
  logic [3:0] pos;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic chk_op(input string tag, input logic [31:0] val, input logic [4:0] id, input logic [36:0] exp);
    chk({tag, "_rob_id"}, 32'(id), 32'(exp[4:0]));
    if (exp[4:0] == 5'd0) chk({tag, "_val"}, val, exp[36:5]);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.if_valid = 1'b0; bus.if_inst = 32'd0; bus.if_pc = 32'd0;
    bus.if_pred_jump = 1'b0; bus.rf_rs1_val = 32'd0; bus.rf_rs2_val = 32'd0; bus.rf_rs1_rob_id = 5'd0;
    bus.rf_rs2_rob_id = 5'd0; bus.rob_rs1_ready = 1'b0; bus.rob_rs2_ready = 1'b0; bus.rob_rs1_val = 32'd0;
    bus.rob_rs2_val = 32'd0; bus.rob_nxt_full = 1'b0; bus.rs_nxt_full = 1'b0; bus.lsb_nxt_full = 1'b0;
    bus.rob_nxt_pos = 4'd0; bus.alu_result = 1'b0; bus.alu_result_rob_pos = 4'd0; bus.alu_result_val = 32'd0;
    bus.lsb_result = 1'b0; bus.lsb_result_rob_pos = 4'd0; bus.lsb_result_val = 32'd0;
  endtask
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    int s;
    s = $signed(x);
    case (x[6:0])
      7'h13, 7'h03, 7'h67: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) * 32 + int'(x[11:7]));
      7'h63: return 32'(-4096 * int'(x[31]) + 2048 * int'(x[7]) + 32 * int'(x[30:25]) + 2 * int'(x[11:8]));
      7'h37, 7'h17: return x - (x % 32'd4096);
      7'h6f: return 32'(-1048576 * int'(x[31]) + 4096 * int'(x[19:12]) + 2048 * int'(x[20]) + 2 * int'(x[30:21]));
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [36:0] ref_byp(input logic [36:0] o);
    if (o[4] && bus.alu_result && bus.alu_result_rob_pos == o[3:0]) return {bus.alu_result_val, 5'd0};
    if (o[4] && bus.lsb_result && bus.lsb_result_rob_pos == o[3:0]) return {bus.lsb_result_val, 5'd0};
    return o;
  endfunction
  function automatic logic [36:0] ref_src(input logic [4:0] rs, input logic used, input logic [31:0] rfv,
                                          input logic [4:0] rfid, input logic robr, input logic [31:0] robv);
    if (!used || rs == 5'd0) return 37'd0;
    if (rfid == 5'd0) return {rfv, 5'd0};
    if (ref_byp({32'd0, rfid}) != {32'd0, rfid}) return ref_byp({32'd0, rfid});
    if (robr) return {robv, 5'd0};
    return {32'd0, rfid};
  endfunction
  initial begin
    idle();
    step();
    step();
    @(negedge clk);
    chk("reset_rob_issue", 32'(bus.rob_issue), 32'd0);
    chk("reset_rs_issue", 32'(bus.rs_issue), 32'd0);
    chk("reset_lsb_issue", 32'(bus.lsb_issue), 32'd0);
    chk("reset_if_ready", 32'(bus.if_ready), 32'd1);
    rst = 1'b0;
    step();
    bus.if_valid = 1'b1; bus.if_inst = 32'h00500093; bus.if_pc = 32'h1000;
    @(negedge clk);
    chk("addi_accept", 32'(bus.if_ready), 32'd1);
    step();
    bus.if_inst = 32'h002081b3; bus.if_pc = 32'h1004; bus.rob_nxt_pos = 4'd2;
    bus.rf_rs1_val = 32'h11111111; bus.rf_rs2_val = 32'h22222222;
    @(negedge clk);
    chk("addi_rs_issue", 32'(bus.rs_issue), 32'd1);
    chk("addi_rob_issue", 32'(bus.rob_issue), 32'd1);
    chk("addi_lsb_issue", 32'(bus.lsb_issue), 32'd0);
    chk("addi_imm", bus.issue_imm, 32'd5);
    chk_op("addi_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, 37'd0);
    chk("addi_rename", 32'(bus.rf_rename), 32'd1);
    chk("addi_rd", 32'(bus.issue_rd), 32'd1);
    chk("addi_rob_pos", 32'(bus.issue_rob_pos), 32'd2);
    chk("addi_pc", bus.issue_pc, 32'h1000);
    step();
    bus.if_inst = 32'h0081a203; bus.if_pc = 32'h1008; bus.rob_nxt_pos = 4'd3;
    @(negedge clk);
    chk_op("add_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, {32'd0, 5'b10010});
    chk_op("add_rs2", bus.issue_rs2_val, bus.issue_rs2_rob_id, {32'h22222222, 5'd0});
    chk("add_rd", 32'(bus.issue_rd), 32'd3);
    chk("add_rs_issue", 32'(bus.rs_issue), 32'd1);
    chk("add_opcode", 32'(bus.issue_opcode), 32'h33);
    step();
    bus.if_inst = 32'h00500093; bus.rob_nxt_pos = 4'd4; bus.rs_nxt_full = 1'b1; bus.lsb_nxt_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lw_stall_if_ready", 32'(bus.if_ready), 32'd0);
      chk("lw_stall_lsb_issue", 32'(bus.lsb_issue), 32'd0);
      chk("lw_stall_imm", bus.issue_imm, 32'd8);
      chk_op("lw_stall_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, {32'd0, 5'b10011});
      step();
    end
    bus.lsb_nxt_full = 1'b0; bus.if_valid = 1'b0;
    @(negedge clk);
    chk("lw_lsb_issue", 32'(bus.lsb_issue), 32'd1);
    chk("lw_rs_issue", 32'(bus.rs_issue), 32'd0);
    chk("lw_rob_issue", 32'(bus.rob_issue), 32'd1);
    chk("lw_rename", 32'(bus.rf_rename), 32'd1);
    chk("lw_funct3", 32'(bus.issue_funct3), 32'd2);
    step();
    idle();
    bus.if_valid = 1'b1; bus.if_inst = 32'h00532023; bus.rf_rs2_rob_id = 5'h17; bus.rf_rs1_val = 32'h100;
    @(negedge clk);
    chk("empty_rob_issue", 32'(bus.rob_issue), 32'd0);
    step();
    idle();
    bus.lsb_nxt_full = 1'b1;
    @(negedge clk);
    chk_op("sw_rs2_pending", bus.issue_rs2_val, bus.issue_rs2_rob_id, {32'd0, 5'h17});
    step();
    bus.alu_result = 1'b1; bus.alu_result_rob_pos = 4'd7; bus.alu_result_val = 32'hdead;
    @(negedge clk);
    chk_op("sw_rs2_bypass", bus.issue_rs2_val, bus.issue_rs2_rob_id, {32'hdead, 5'd0});
    chk_op("sw_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, {32'h100, 5'd0});
    chk("sw_rename", 32'(bus.rf_rename), 32'd0);
    step();
    bus.alu_result = 1'b0;
    @(negedge clk);
    chk_op("sw_rs2_held", bus.issue_rs2_val, bus.issue_rs2_rob_id, {32'hdead, 5'd0});
    bus.lsb_nxt_full = 1'b0;
    #1;
    chk("sw_lsb_issue", 32'(bus.lsb_issue), 32'd1);
    step();
    bus.if_valid = 1'b1; bus.if_inst = 32'h00500093; bus.rs_nxt_full = 1'b1;
    step();
    bus.rollback = 1'b1;
    @(negedge clk);
    chk("rb_rob_issue", 32'(bus.rob_issue), 32'd0);
    chk("rb_rs_issue", 32'(bus.rs_issue), 32'd0);
    chk("rb_if_ready", 32'(bus.if_ready), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("rb_empty_rob_issue", 32'(bus.rob_issue), 32'd0);
    chk("rb_if_ready_after", 32'(bus.if_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.if_valid = 1'b1; bus.if_inst = t_inst[k];
      step();
      bus.if_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("dec%0d_imm", k), bus.issue_imm, t_imm[k]);
      chk($sformatf("dec%0d_rename", k), 32'(bus.rf_rename), 32'(t_ren[k]));
      chk($sformatf("dec%0d_funct7", k), 32'(bus.issue_funct7), 32'(t_f7[k]));
      chk($sformatf("dec%0d_rs_issue", k), 32'(bus.rs_issue), 32'd1);
      step();
    end
    for (int k = 0; k < 300; k++) begin
      idle();
      inst = $urandom();
      if ($urandom_range(0, 9) != 0) inst[6:0] = ops[$urandom_range(0, 8)];
      pc = $urandom(); pj = 1'($urandom_range(0, 1));
      bus.if_valid = 1'b1; bus.if_inst = inst; bus.if_pc = pc; bus.if_pred_jump = pj;
      bus.rf_rs1_rob_id = $urandom_range(0, 1) != 0 ? {1'b1, 4'($urandom_range(0, 15))} : 5'd0;
      bus.rf_rs2_rob_id = $urandom_range(0, 1) != 0 ? {1'b1, 4'($urandom_range(0, 15))} : 5'd0;
      bus.rf_rs1_val = $urandom(); bus.rf_rs2_val = $urandom();
      bus.rob_rs1_ready = 1'($urandom_range(0, 1)); bus.rob_rs2_ready = 1'($urandom_range(0, 1));
      bus.rob_rs1_val = $urandom(); bus.rob_rs2_val = $urandom();
      bus.alu_result = 1'($urandom_range(0, 1)); bus.alu_result_val = $urandom();
      bus.alu_result_rob_pos = $urandom_range(0, 1) != 0 ? bus.rf_rs1_rob_id[3:0] : 4'($urandom_range(0, 15));
      bus.lsb_result = 1'($urandom_range(0, 1)); bus.lsb_result_val = $urandom();
      bus.lsb_result_rob_pos = $urandom_range(0, 1) != 0 ? bus.rf_rs2_rob_id[3:0] : 4'($urandom_range(0, 15));
      if (bus.alu_result && bus.lsb_result && bus.alu_result_rob_pos == bus.lsb_result_rob_pos) bus.lsb_result = 1'b0;
      @(negedge clk);
      chk("rnd_if_ready", 32'(bus.if_ready), 32'd1);
      chk("rnd_rf_rs1_pos", 32'(bus.rf_rs1_pos), 32'(inst[19:15]));
      chk("rnd_rob_rs2_pos", 32'(bus.rob_rs2_pos), 32'(bus.rf_rs2_rob_id[3:0]));
      ea = ref_src(inst[19:15], !(inst[6:0] inside {7'h37, 7'h17, 7'h6f}), bus.rf_rs1_val, bus.rf_rs1_rob_id,
                   bus.rob_rs1_ready, bus.rob_rs1_val);
      eb = ref_src(inst[24:20], inst[6:0] inside {7'h33, 7'h23, 7'h63}, bus.rf_rs2_val, bus.rf_rs2_rob_id,
                   bus.rob_rs2_ready, bus.rob_rs2_val);
      step();
      idle();
      rdy_now = $urandom_range(0, 3) != 0;
      bus.rdy = rdy_now;
      bus.rob_nxt_full = $urandom_range(0, 3) == 0;
      bus.rs_nxt_full = $urandom_range(0, 3) == 0;
      bus.lsb_nxt_full = $urandom_range(0, 3) == 0;
      bus.rob_nxt_pos = 4'($urandom_range(0, 15));
      pos = 4'($urandom_range(0, 15));
      bus.alu_result = 1'($urandom_range(0, 1)); bus.alu_result_val = $urandom();
      bus.alu_result_rob_pos = $urandom_range(0, 1) != 0 ? ea[3:0] : pos;
      bus.lsb_result = 1'($urandom_range(0, 1)); bus.lsb_result_val = $urandom();
      bus.lsb_result_rob_pos = $urandom_range(0, 1) != 0 ? eb[3:0] : ~pos;
      if (bus.alu_result && bus.lsb_result && bus.alu_result_rob_pos == bus.lsb_result_rob_pos) bus.lsb_result = 1'b0;
      @(negedge clk);
      lsb = inst[6:0] == 7'h03 || inst[6:0] == 7'h23;
      go = !bus.rob_nxt_full && !(lsb ? bus.lsb_nxt_full : bus.rs_nxt_full);
      ba = ref_byp(ea);
      bb = ref_byp(eb);
      chk("rnd_rob_issue", 32'(bus.rob_issue), 32'(go));
      chk("rnd_rs_issue", 32'(bus.rs_issue), 32'(go && !lsb));
      chk("rnd_lsb_issue", 32'(bus.lsb_issue), 32'(go && lsb));
      chk("rnd_rename", 32'(bus.rf_rename),
          32'(go && inst[11:7] != 5'd0 && inst[6:0] != 7'h23 && inst[6:0] != 7'h63));
      chk("rnd_imm", bus.issue_imm, ref_imm(inst));
      chk("rnd_fields", {15'd0, bus.issue_opcode, bus.issue_funct3, bus.issue_rd, bus.issue_funct7, bus.issue_pred_jump},
          {15'd0, inst[6:0], inst[14:12], inst[11:7],
           (inst[6:0] == 7'h33 || (inst[6:0] == 7'h13 && inst[14:12] == 3'd5)) && inst[30], pj});
      chk("rnd_pc", bus.issue_pc, pc);
      chk("rnd_rob_pos", 32'(bus.issue_rob_pos), 32'(bus.rob_nxt_pos));
      chk_op("rnd_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, ba);
      chk_op("rnd_rs2", bus.issue_rs2_val, bus.issue_rs2_rob_id, bb);
      step();
      pend = !(rdy_now && go);
      if (rdy_now) begin
        ea = ba;
        eb = bb;
      end
      if (pend) begin
        idle();
        @(negedge clk);
        chk("rnd_release_issue", 32'(bus.rob_issue), 32'd1);
        chk_op("rnd_held_rs1", bus.issue_rs1_val, bus.issue_rs1_rob_id, ea);
        chk_op("rnd_held_rs2", bus.issue_rs2_val, bus.issue_rs2_rob_id, eb);
        step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
